// File: rtl/clint.sv
// ---------------------------------------------------------------------------
// clint -- core-local interruptor
//
// Memory-mapped 64-bit machine timer (mtime / mtimecmp) and the machine
// software-interrupt bit (msip). IRQ3 carries msip[0] and IRQ7 carries the
// timer compare (mtime >= mtimecmp) into the CSR unit. The block sits on the
// CPU data bus as a valid/ready slave.
//
// Register map (byte offsets, addr[1:0] ignored):
//   0x0000 msip (bit 0 only)      0x4000 mtimecmp[31:0]   0x4004 mtimecmp[63:32]
//   0xBFF8 mtime[31:0]            0xBFFC mtime[63:32]
//   Any other offset reads 0, ignores writes and is still acknowledged.
//
// Parameters:
//   TICK_DIV   clk cycles per mtime increment (>= 1)
//   DIV_WIDTH  prescaler width; TICK_DIV-1 must fit
//
// Ports:
//   clk     in   system clock
//   resetn  in   asynchronous active-low reset
//   valid   in   bus request, held until ready
//   ready   out  one-cycle acknowledge pulse
//   addr    in   [15:0] byte offset inside the CLINT window
//   wdata   in   [31:0] write data
//   wstrb   in   [3:0]  byte enables, 4'b0000 means read
//   rdata   out  [31:0] read data, valid while ready=1, 0 otherwise
//   IRQ3    out  machine software interrupt
//   IRQ7    out  machine timer interrupt
// ---------------------------------------------------------------------------
module clint #(
    parameter int TICK_DIV  = 1,
    parameter int DIV_WIDTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        IRQ3,
    output logic        IRQ7
);

    // Word addresses (byte offset >> 2)
    localparam logic [13:0] A_MSIP   = 14'h0000;
    localparam logic [13:0] A_CMP_LO = 14'h1000;
    localparam logic [13:0] A_CMP_HI = 14'h1001;
    localparam logic [13:0] A_MT_LO  = 14'h2FFE;
    localparam logic [13:0] A_MT_HI  = 14'h2FFF;

    localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(TICK_DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic                  r_msip;
    logic [DIV_WIDTH-1:0]  r_presc;
    logic                  r_irq3;
    logic                  r_irq7;

    logic [13:0]           w_word;
    logic                  w_req;
    logic                  w_wr;
    logic                  w_tick;
    logic [31:0]           w_wmask;
    logic [31:0]           w_rdata;
    logic [31:0]           w_cmp_lo_new;
    logic [31:0]           w_cmp_hi_new;
    logic [31:0]           w_mt_lo_new;
    logic [31:0]           w_mt_hi_new;
    logic                  w_unused_addr;

    assign w_word        = addr[15:2];
    assign w_unused_addr = ^addr[1:0];

    // A request is only taken in IDLE, so a valid held through ACK cannot
    // be accepted twice.
    assign w_req = (r_state == ST_IDLE) && valid;
    assign w_wr  = w_req && (wstrb != 4'b0000);

    // Expand byte strobes into a bit mask for read-modify-write merges.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            assign w_wmask[8*gi +: 8] = {8{wstrb[gi]}};
        end
    endgenerate

    assign w_cmp_lo_new = (r_mtimecmp[31:0]  & ~w_wmask) | (wdata & w_wmask);
    assign w_cmp_hi_new = (r_mtimecmp[63:32] & ~w_wmask) | (wdata & w_wmask);
    assign w_mt_lo_new  = (r_mtime[31:0]     & ~w_wmask) | (wdata & w_wmask);
    assign w_mt_hi_new  = (r_mtime[63:32]    & ~w_wmask) | (wdata & w_wmask);

    // Read mux works on pre-edge register values, so an mtime read returns
    // the count before any increment happening on the same edge.
    always_comb begin
        w_rdata = 32'h0;
        case (w_word)
            A_MSIP:   w_rdata = {31'h0, r_msip};
            A_CMP_LO: w_rdata = r_mtimecmp[31:0];
            A_CMP_HI: w_rdata = r_mtimecmp[63:32];
            A_MT_LO:  w_rdata = r_mtime[31:0];
            A_MT_HI:  w_rdata = r_mtime[63:32];
            default:  w_rdata = 32'h0;
        endcase
    end

    // Bus FSM with registered ready/rdata.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid) begin
                        r_state <= ST_ACK;
                        r_ready <= 1'b1;
                        r_rdata <= w_rdata;
                    end else begin
                        r_ready <= 1'b0;
                        r_rdata <= 32'h0;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_rdata <= 32'h0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_rdata <= 32'h0;
                end
            endcase
        end
    end

    // Free-running prescaler; bus traffic never touches it.
    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + DIV_WIDTH'(1);
        end
    end

    // mtime: a write to either half takes priority over the tick and
    // suppresses the increment entirely (no carry into the other half).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mtime <= 64'h0;
        end else if (w_wr && (w_word == A_MT_LO)) begin
            r_mtime[31:0] <= w_mt_lo_new;
        end else if (w_wr && (w_word == A_MT_HI)) begin
            r_mtime[63:32] <= w_mt_hi_new;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'h1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_msip     <= 1'b0;
        end else if (w_wr) begin
            case (w_word)
                A_CMP_LO: r_mtimecmp[31:0]  <= w_cmp_lo_new;
                A_CMP_HI: r_mtimecmp[63:32] <= w_cmp_hi_new;
                A_MSIP:   if (wstrb[0]) r_msip <= wdata[0];
                default:  ;
            endcase
        end
    end

    // Interrupt outputs are registered from the current register state,
    // giving one cycle of latency after the condition holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq3 <= 1'b0;
            r_irq7 <= 1'b0;
        end else begin
            r_irq3 <= r_msip;
            r_irq7 <= (r_mtime >= r_mtimecmp);
        end
    end

    assign ready = r_ready;
    assign rdata = r_rdata;
    assign IRQ3  = r_irq3;
    assign IRQ7  = r_irq7;

endmodule

// File: tb/tb_clint.sv
// ---------------------------------------------------------------------------
// tb_clint -- self-checking bench for clint.
//
// Two instances share clock and reset: u_dut1 with TICK_DIV=1 and u_dut4 with
// TICK_DIV=4. Read expectations are pushed to a scoreboard queue when a
// request is driven and popped when the DUT raises ready. mtime is tracked
// as (base value, edge it was set on) plus the number of ticks since then,
// counted in clock edges after reset release.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clint;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid1, valid4;
    logic        ready1, ready4;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata1, rdata4;
    logic        irq3_1, irq7_1, irq3_4, irq7_4;

    always #5 clk = ~clk;

    clint #(.TICK_DIV(1), .DIV_WIDTH(16)) u_dut1 (
        .clk(clk), .resetn(resetn), .valid(valid1), .ready(ready1),
        .addr(addr), .wdata(wdata), .wstrb(wstrb), .rdata(rdata1),
        .IRQ3(irq3_1), .IRQ7(irq7_1)
    );

    clint #(.TICK_DIV(4), .DIV_WIDTH(16)) u_dut4 (
        .clk(clk), .resetn(resetn), .valid(valid4), .ready(ready4),
        .addr(addr), .wdata(wdata), .wstrb(wstrb), .rdata(rdata4),
        .IRQ3(irq3_4), .IRQ7(irq7_4)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rel_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference state per instance (index 0: TICK_DIV=1, index 1: TICK_DIV=4)
    logic [63:0] m_base  [2];
    int          m_bedge [2];
    logic [63:0] m_cmp   [2];
    logic        m_msip  [2];

    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int divof(input int sel);
        return (sel == 0) ? 1 : 4;
    endfunction

    // mtime value just before relative edge e (ticks fall on edges e % D == 0)
    function automatic logic [63:0] mt_pre(input int sel, input int e);
        int d;
        d = divof(sel);
        return m_base[sel] + 64'(((e - 1) / d) - (m_bedge[sel] / d));
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ready1 : ready4;
    endfunction
    function automatic logic [31:0] rd(input int sel);
        return (sel == 0) ? rdata1 : rdata4;
    endfunction
    function automatic logic irq3(input int sel);
        return (sel == 0) ? irq3_1 : irq3_4;
    endfunction
    function automatic logic irq7(input int sel);
        return (sel == 0) ? irq7_1 : irq7_4;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_base[s]  = 64'h0;
            m_bedge[s] = 0;
            m_cmp[s]   = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip[s]  = 1'b0;
        end
    endtask

    task automatic pop_compare(input int sel);
        string t;
        logic [31:0] ev;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            t  = tag_q.pop_front();
            ev = exp_q.pop_front();
            check(t, rd(sel), ev);
        end
    endtask

    // One bus transaction. align>1 delays the request so it commits on a
    // prescaler tick edge of that divisor.
    task automatic xfer(input int sel, input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int align);
        int          e;
        bit          got;
        logic [31:0] expv;
        logic [63:0] cur;
        logic [15:0] wa;
        @(negedge clk);
        if (align > 1)
            while (((cyc + 1 - rel_cyc) % align) != 0) @(negedge clk);
        e    = cyc + 1 - rel_cyc;
        wa   = {a[15:2], 2'b00};
        cur  = mt_pre(sel, e);
        case (wa)
            16'h0000: expv = {31'h0, m_msip[sel]};
            16'h4000: expv = m_cmp[sel][31:0];
            16'h4004: expv = m_cmp[sel][63:32];
            16'hBFF8: expv = cur[31:0];
            16'hBFFC: expv = cur[63:32];
            default:  expv = 32'h0;
        endcase
        if (st == 4'b0000) begin
            exp_q.push_back(expv);
            tag_q.push_back($sformatf("rd_dut%0d_%04h", sel, a));
        end else begin
            case (wa)
                16'h0000: if (st[0]) m_msip[sel] = wd[0];
                16'h4000: m_cmp[sel][31:0]  = mrg(m_cmp[sel][31:0], wd, st);
                16'h4004: m_cmp[sel][63:32] = mrg(m_cmp[sel][63:32], wd, st);
                16'hBFF8: begin
                    m_base[sel]  = {cur[63:32], mrg(cur[31:0], wd, st)};
                    m_bedge[sel] = e;
                end
                16'hBFFC: begin
                    m_base[sel]  = {mrg(cur[63:32], wd, st), cur[31:0]};
                    m_bedge[sel] = e;
                end
                default: ;
            endcase
        end
        addr  = a;
        wdata = wd;
        wstrb = st;
        if (sel == 0) valid1 = 1'b1; else valid4 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (rdy(sel)) begin
                got = 1'b1;
                check("ack_latency", i, 0);
            end
        end
        if (!got) begin
            check("ack_timeout", 0, 1);
            if (st == 4'b0000 && exp_q.size() > 0) begin
                void'(exp_q.pop_back());
                void'(tag_q.pop_back());
            end
        end else if (st == 4'b0000) begin
            pop_compare(sel);
        end
        $display("xfer dut%0d addr=%04h wdata=%08h wstrb=%b rdata=%08h", sel, a, wd, st, rd(sel));
        valid1 = 1'b0;
        valid4 = 1'b0;
        @(posedge clk); #1;
        check("ready_pulse", rdy(sel), 0);
        check("irq3_after", irq3(sel), m_msip[sel]);
        check("irq7_after", irq7(sel), mt_pre(sel, e + 1) >= m_cmp[sel]);
    endtask

    // Per-cycle IRQ7 tracking while no register writes occur.
    task automatic watch(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("irq7_track", irq7(sel), mt_pre(sel, cyc - rel_cyc) >= m_cmp[sel]);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ready1", ready1, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_irq3_1", irq3_1, 0);
        check("rst_irq7_1", irq7_1, 0);
        check("rst_ready4", ready4, 0);
        check("rst_rdata4", rdata4, 0);
        check("rst_irq3_4", irq3_4, 0);
        check("rst_irq7_4", irq7_4, 0);
    endtask

    initial begin
        resetn = 1'b0;
        valid1 = 1'b0;
        valid4 = 1'b0;
        addr   = 16'h0;
        wdata  = 32'h0;
        wstrb  = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        resetn  = 1'b1;
        rel_cyc = cyc;
        repeat (10) @(posedge clk);

        // Reset values and basic reads
        xfer(0, 16'hBFF8, 0, 4'h0, 0);
        xfer(0, 16'hBFFC, 0, 4'h0, 0);
        xfer(0, 16'h4000, 0, 4'h0, 0);
        xfer(0, 16'h4004, 0, 4'h0, 0);
        xfer(0, 16'h0000, 0, 4'h0, 0);
        xfer(0, 16'h1234, 0, 4'h0, 0);
        xfer(1, 16'hBFF8, 0, 4'h0, 0);
        xfer(1, 16'h4004, 0, 4'h0, 0);

        // Timer compare: IRQ7 rises after mtime reaches 0x20, falls on hi=all-ones
        xfer(0, 16'hBFF8, 32'h0, 4'hF, 0);
        xfer(0, 16'h4000, 32'h20, 4'hF, 0);
        xfer(0, 16'h4004, 32'h0, 4'hF, 0);
        watch(0, 40);
        xfer(0, 16'h4004, 32'hFFFF_FFFF, 4'hF, 0);
        watch(0, 3);

        // Software interrupt and strobe handling
        xfer(0, 16'h0000, 32'h1, 4'b0001, 0);
        xfer(0, 16'h0000, 0, 4'h0, 0);
        xfer(0, 16'h0000, 32'h0, 4'b0010, 0);
        xfer(0, 16'h0000, 0, 4'h0, 0);
        xfer(0, 16'h0000, 32'h0, 4'b0001, 0);
        xfer(0, 16'h0000, 0, 4'h0, 0);

        // Partial byte writes on mtimecmp
        xfer(0, 16'h4000, 32'hAABB_CCDD, 4'hF, 0);
        xfer(0, 16'h4000, 32'h1122_3344, 4'b0101, 0);
        xfer(0, 16'h4000, 0, 4'h0, 0);

        // Carry from lo into hi, then full 64-bit wrap
        xfer(0, 16'hBFFC, 32'h0, 4'hF, 0);
        xfer(0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 0);
        xfer(0, 16'hBFFC, 0, 4'h0, 0);
        xfer(0, 16'hBFF8, 0, 4'h0, 0);
        xfer(0, 16'h4000, 32'h100, 4'hF, 0);
        xfer(0, 16'h4004, 32'h0, 4'hF, 0);
        xfer(0, 16'hBFF8, 32'hFFFF_FFF0, 4'hF, 0);
        xfer(0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 0);
        watch(0, 30);
        xfer(0, 16'hBFFC, 0, 4'h0, 0);
        xfer(0, 16'hBFF8, 0, 4'h0, 0);

        // TICK_DIV=4: writes coincident with a tick win, no +1
        xfer(1, 16'hBFF8, 32'h1000, 4'hF, 4);
        xfer(1, 16'hBFF8, 0, 4'h0, 0);
        xfer(1, 16'hBFFC, 32'h5, 4'hF, 4);
        xfer(1, 16'hBFFC, 0, 4'h0, 0);
        repeat (9) @(negedge clk);
        xfer(1, 16'hBFF8, 0, 4'h0, 0);
        xfer(1, 16'hBFF8, 0, 4'h0, 0);

        // valid held across ACK: second ready only after one IDLE cycle
        @(negedge clk);
        exp_q.push_back(m_cmp[0][31:0]);  tag_q.push_back("hold_rd1");
        exp_q.push_back(m_cmp[0][31:0]);  tag_q.push_back("hold_rd2");
        addr = 16'h4000; wstrb = 4'h0; valid1 = 1'b1;
        @(posedge clk); #1;
        check("hold_ack1", ready1, 1);
        pop_compare(0);
        @(posedge clk); #1;
        check("hold_gap", ready1, 0);
        @(posedge clk); #1;
        check("hold_ack2", ready1, 1);
        pop_compare(0);
        valid1 = 1'b0;
        @(posedge clk); #1;
        check("hold_end", ready1, 0);

        // Reset asserted while in ACK
        xfer(0, 16'h4000, 32'h0, 4'hF, 0);
        xfer(0, 16'h0000, 32'h1, 4'b0001, 0);
        @(negedge clk);
        exp_q.push_back({31'h0, m_msip[0]}); tag_q.push_back("pre_rst_msip");
        addr = 16'h0000; wstrb = 4'h0; valid1 = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_ack", ready1, 1);
        pop_compare(0);
        #1 resetn = 1'b0;
        #1;
        check_reset_outputs();
        valid1 = 1'b0;
        repeat (2) @(negedge clk);
        resetn  = 1'b1;
        rel_cyc = cyc;
        model_reset();
        repeat (3) @(posedge clk);
        xfer(0, 16'h4000, 0, 4'h0, 0);
        xfer(0, 16'h4004, 0, 4'h0, 0);
        xfer(0, 16'h0000, 0, 4'h0, 0);
        xfer(0, 16'hBFF8, 0, 4'h0, 0);
        xfer(1, 16'hBFF8, 0, 4'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
